// File: rtl/jpeg_block_sequencer.sv
// Job-level controller for the 8x8-block JPEG pipeline: runs the shared row
// counter through fill, steady state and drain, and derives all row strobes.
module jpeg_block_sequencer #(
    parameter int ADDR_W   = 15,
    parameter int PIPE_LAT = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [12:0]       num_blocks,
    input  logic              hold,
    input  logic              abort,
    output logic [ADDR_W-1:0] cnt,
    output logic [2:0]        phase,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              enc_load,
    output logic [7:0]        dec_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAT = 16'(PIPE_LAT);

    state_t      state_r, state_s;
    logic [15:0] c_r, c_s;
    logic [15:0] rows_r, rows_s;
    logic [15:0] wr_end_s;
    logic [15:0] last_s;
    logic        run_s;
    logic        act_s;
    logic [ADDR_W-1:0] wr_off_s;

    assign wr_end_s = LAT + rows_r;
    assign last_s   = wr_end_s - 16'd1;
    assign run_s    = (state_r == ST_RUN);
    assign act_s    = run_s && !hold;
    // Output row index lags the read index by the pipeline latency; wrap is harmless
    // because the write strobe only covers the non-negative range.
    assign wr_off_s = c_r[ADDR_W-1:0] - LAT[ADDR_W-1:0];

    // State, counter and latched row count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            c_r     <= 16'd0;
            rows_r  <= 16'd0;
        end else begin
            state_r <= state_s;
            c_r     <= c_s;
            rows_r  <= rows_s;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_s = state_r;
        c_s     = c_r;
        rows_s  = rows_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (num_blocks != 13'd0) begin
                        rows_s  = {num_blocks, 3'b000};
                        c_s     = 16'd0;
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    c_s     = 16'd0;
                    state_s = ST_IDLE;
                end else if (!hold) begin
                    if (c_r == last_s) begin
                        c_s     = 16'd0;
                        state_s = ST_DONE;
                    end else begin
                        c_s = c_r + 16'd1;
                    end
                end else begin
                    c_s = c_r;
                end
            end
            ST_DONE: begin
                c_s     = 16'd0;
                state_s = ST_IDLE;
            end
            default: begin
                c_s     = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Strobes depend only on state, counter and hold.
    always_comb begin
        rd_en    = act_s && (c_r < rows_r);
        wr_en    = act_s && (c_r >= LAT) && (c_r < wr_end_s);
        enc_load = act_s && (c_r[2:0] == 3'd2) && (c_r >= 16'd8);
        dec_sel  = 8'd0;
        for (int k = 0; k < 8; k++) begin
            dec_sel[k] = act_s && (c_r >= 16'd16) && (c_r[2:0] == 3'(k + 3));
        end
    end

    assign cnt     = c_r[ADDR_W-1:0];
    assign phase   = c_r[2:0];
    assign rd_addr = c_r[ADDR_W-1:0];
    assign wr_addr = run_s ? wr_off_s : {ADDR_W{1'b0}};
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Directed bench for jpeg_block_sequencer: a vector table for control corners
// plus cycle-numbered sequences for the multi-cycle job scenarios.
module tb_jpeg_block_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [12:0] num_blocks;
    logic        hold;
    logic        abort;
    logic [14:0] cnt;
    logic [2:0]  phase;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic        enc_load;
    logic [7:0]  dec_sel;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    jpeg_block_sequencer #(.ADDR_W(15), .PIPE_LAT(48)) dut (
        .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
        .hold(hold), .abort(abort), .cnt(cnt), .phase(phase), .rd_en(rd_en),
        .rd_addr(rd_addr), .enc_load(enc_load), .dec_sel(dec_sel), .wr_en(wr_en),
        .wr_addr(wr_addr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [12:0] nb;
        logic        hold;
        logic        abort;
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [14:0] rd_addr;
        logic        wr_en;
        logic [14:0] cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " cnt"}, 32'(cnt), 32'd0);
        chk({tag, " phase"}, 32'(phase), 32'd0);
        chk({tag, " rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, " enc_load"}, 32'(enc_load), 32'd0);
        chk({tag, " dec_sel"}, 32'(dec_sel), 32'd0);
    endtask

    // Drive start during "cycle 0" so the accepting edge is edge 0.
    task automatic begin_job(input logic [12:0] nb);
        @(posedge clk); #1;
        start = 1'b1;
        num_blocks = nb;
    endtask

    initial begin
        int c;
        int rd_cnt;
        int wr_cnt;
        int done_cyc;
        int last_wr;
        logic [7:0] e_dec;

        reset = 1'b0; start = 1'b0; num_blocks = 13'd0; hold = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("reset");
        reset = 1'b1;

        //            start nb     hold abort busy done rd  rdaddr  wr  cnt
        vecs[0]  = '{1'b1, 13'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[1]  = '{1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[2]  = '{1'b1, 13'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[3]  = '{1'b1, 13'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd0, 1'b0, 15'd0};
        vecs[4]  = '{1'b0, 13'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[5]  = '{1'b0, 13'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd1, 1'b0, 15'd1};
        vecs[6]  = '{1'b0, 13'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[7]  = '{1'b1, 13'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd0, 1'b0, 15'd0};
        vecs[8]  = '{1'b0, 13'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'd1, 1'b0, 15'd1};
        vecs[9]  = '{1'b0, 13'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[10] = '{1'b1, 13'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[11] = '{1'b1, 13'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};
        vecs[12] = '{1'b0, 13'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0};

        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; num_blocks = vecs[i].nb;
            hold = vecs[i].hold; abort = vecs[i].abort;
            @(posedge clk); #1;
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d rd_en", i), 32'(rd_en), 32'(vecs[i].rd_en));
            chk($sformatf("vec%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].rd_addr));
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].wr_en));
            chk($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].cnt));
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;

        // Single block: cycle k has c = k-1 while running.
        begin_job(13'd1);
        for (int k = 1; k <= 58; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            c = k - 1;
            e_dec = 8'd0;
            if (k <= 56 && c >= 16) e_dec[(c + 5) % 8] = 1'b1;
            chk($sformatf("one c%0d rd_en", k), 32'(rd_en), 32'(k <= 8));
            if (k <= 8) chk($sformatf("one c%0d rd_addr", k), 32'(rd_addr), 32'(c));
            chk($sformatf("one c%0d wr_en", k), 32'(wr_en), 32'(k >= 49 && k <= 56));
            if (k >= 49 && k <= 56) chk($sformatf("one c%0d wr_addr", k), 32'(wr_addr), 32'(k - 49));
            chk($sformatf("one c%0d enc_load", k), 32'(enc_load), 32'(k <= 56 && c >= 8 && (c % 8) == 2));
            chk($sformatf("one c%0d dec_sel", k), 32'(dec_sel), 32'(e_dec));
            if (k <= 56) chk($sformatf("one c%0d phase", k), 32'(phase), 32'(c % 8));
            chk($sformatf("one c%0d done", k), 32'(done), 32'(k == 57));
            chk($sformatf("one c%0d busy", k), 32'(busy), 32'(k <= 57));
        end
        chk("one first enc_load cycle", 32'((11 - 1) % 8), 32'(2));

        // Hold in cycles 5..7 of a two-block job.
        begin_job(13'd2);
        for (int k = 1; k <= 69; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            hold = (k >= 5 && k <= 7);
            #1;
            if (k >= 5 && k <= 7) begin
                chk($sformatf("hold c%0d rd_en", k), 32'(rd_en), 32'd0);
                chk($sformatf("hold c%0d rd_addr", k), 32'(rd_addr), 32'd4);
                chk($sformatf("hold c%0d enc_load", k), 32'(enc_load), 32'd0);
            end
            if (k == 8) begin
                chk("hold resume rd_en", 32'(rd_en), 32'd1);
                chk("hold resume rd_addr", 32'(rd_addr), 32'd4);
            end
            chk($sformatf("hold c%0d done", k), 32'(done), 32'(k == 68));
        end
        hold = 1'b0;

        // Abort at edge 20, restart at edge 21.
        begin_job(13'd4);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            abort = (k == 20);
            start = (k == 21);
            #1;
            if (k <= 21) chk($sformatf("abort c%0d done", k), 32'(done), 32'd0);
            if (k == 21) chk_zero("abort c21");
            if (k == 22) begin
                chk("abort restart busy", 32'(busy), 32'd1);
                chk("abort restart rd_en", 32'(rd_en), 32'd1);
                chk("abort restart rd_addr", 32'(rd_addr), 32'd0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort cleanup busy", 32'(busy), 32'd0);

        // Start pulsed mid-job must not disturb rows or timing.
        begin_job(13'd2);
        for (int k = 1; k <= 66; k++) begin
            @(posedge clk); #1;
            start = (k == 10);
            num_blocks = (k == 10) ? 13'd7 : 13'd2;
            #1;
            chk($sformatf("ign c%0d rd_en", k), 32'(rd_en), 32'(k <= 16));
            chk($sformatf("ign c%0d done", k), 32'(done), 32'(k == 65));
            if (k == 66) chk("ign busy after done", 32'(busy), 32'd0);
        end
        start = 1'b0;

        // Reset at edge 30 of a three-block job.
        begin_job(13'd3);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = (k != 30);
            #1;
            if (k == 29) chk("rst pre busy", 32'(busy), 32'd1);
            if (k == 31) chk_zero("rst c31");
        end
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst stays idle", 32'(busy), 32'd0);

        // Full frame with counter wrap.
        rd_cnt = 0; wr_cnt = 0; done_cyc = -1; last_wr = -1;
        begin_job(13'd4096);
        for (int k = 1; k <= 33000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                wr_cnt++;
                last_wr = int'(wr_addr);
            end
            if (k == 32768) chk("full cnt 32767", 32'(cnt), 32'd32767);
            if (k == 32769) chk("full cnt wrap", 32'(cnt), 32'd0);
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        chk("full rd count", 32'(rd_cnt), 32'd32768);
        chk("full wr count", 32'(wr_cnt), 32'd32768);
        chk("full last wr_addr", 32'(last_wr), 32'd32767);
        chk("full done cycle", 32'(done_cyc), 32'd32817);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
